// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared state encodings, grant IDs and widths for the cache arbiter
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_IF  = 2'd1,
        ST_BUSY_MEM = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_MEM = 1'b1;

    localparam int STARVE_W = 3;

endpackage

// File: rtl/cache_arb_pick.sv
// rtl/cache_arb_pick.sv - combinational winner select between IF and MEM requests
//
// Purpose: picks which requester owns the next core transaction. Holds no state;
//          the round-robin pointer / starve flag live in cache_arbiter.
// Ports:
//   if_req, mem_req   pending requests
//   last_gnt          (CACHE_ARB_RR_EN) ID of the requester granted last
//   if_starved        (default build) IF has waited through STARVE_MAX MEM grants
//   gnt_valid         at least one request pending
//   gnt_id            winner, GNT_IF or GNT_MEM
// Configuration: CACHE_ARB_RR_EN selects round-robin tie breaking.
module cache_arb_pick
    import cache_arb_pkg::*;
(
    input  logic if_req,
    input  logic mem_req,
`ifdef CACHE_ARB_RR_EN
    input  logic last_gnt,
`else
    input  logic if_starved,
`endif
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = if_req | mem_req;
        gnt_id    = GNT_IF;
        if (if_req && mem_req) begin
`ifdef CACHE_ARB_RR_EN
            gnt_id = ~last_gnt;
`else
            gnt_id = if_starved ? GNT_IF : GNT_MEM;
`endif
        end else if (mem_req) begin
            gnt_id = GNT_MEM;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - shares one cache core port between IF (read-only) and MEM (read/write)
//
// Purpose: registers the granted request, drives the core's level-req / pulse-ack
//          handshake (one transaction in flight) and returns read data as a
//          one-cycle ack pulse to the requester.
// Ports:
//   clk, rst                      clock; synchronous active-low reset
//   i_if_req/addr/bytes           IF read request, held until o_if_ack
//   o_if_rdata, o_if_ack          IF read data and completion pulse
//   i_mem_req/op/addr/wdata/bytes MEM request (op 0 read, 1 write), held until o_mem_ack
//   o_mem_rdata, o_mem_ack        MEM read data and completion pulse
//   o_core_req/op/addr/wdata/bytes  request to cache core, held until i_core_ack
//   i_core_rdata, i_core_ack      cache core response
// Configuration: CACHE_ARB_RR_EN selects round-robin arbitration; otherwise MEM
//                has priority with STARVE_MAX anti-starvation for IF.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_if_req,
    input  logic [63:0] i_if_addr,
    input  logic [2:0]  i_if_bytes,
    output logic [63:0] o_if_rdata,
    output logic        o_if_ack,
    input  logic        i_mem_req,
    input  logic        i_mem_op,
    input  logic [63:0] i_mem_addr,
    input  logic [63:0] i_mem_wdata,
    input  logic [2:0]  i_mem_bytes,
    output logic [63:0] o_mem_rdata,
    output logic        o_mem_ack,
    output logic        o_core_req,
    output logic        o_core_op,
    output logic [63:0] o_core_addr,
    output logic [63:0] o_core_wdata,
    output logic [2:0]  o_core_bytes,
    input  logic [63:0] i_core_rdata,
    input  logic        i_core_ack
);

    state_e      state_q, state_d;
    logic        core_req_q, core_req_d;
    logic        core_op_q, core_op_d;
    logic [63:0] core_addr_q, core_addr_d;
    logic [63:0] core_wdata_q, core_wdata_d;
    logic [2:0]  core_bytes_q, core_bytes_d;
    logic [63:0] if_rdata_q, if_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic [63:0] mem_rdata_q, mem_rdata_d;
    logic        mem_ack_q, mem_ack_d;

    logic gnt_valid;
    logic gnt_id;
    logic grant_fire;

    // Requests are only looked at in IDLE; BUSY and DONE let them wait.
    assign grant_fire = (state_q == ST_IDLE) && gnt_valid;

`ifdef CACHE_ARB_RR_EN
    logic last_gnt_q, last_gnt_d;

    cache_arb_pick u_pick (
        .if_req    (i_if_req),
        .mem_req   (i_mem_req),
        .last_gnt  (last_gnt_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (grant_fire) begin
            last_gnt_d = gnt_id;
        end
    end
`else
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                if_starved;

    assign if_starved = (starve_cnt_q >= STARVE_W'(STARVE_MAX));

    cache_arb_pick u_pick (
        .if_req     (i_if_req),
        .mem_req    (i_mem_req),
        .if_starved (if_starved),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // Counts MEM grants taken while IF sits waiting; saturates so it cannot
    // wrap back below the threshold.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_if_req) begin
            starve_cnt_d = '0;
        end else if (grant_fire && (gnt_id == GNT_IF)) begin
            starve_cnt_d = '0;
        end else if (grant_fire && (starve_cnt_q != {STARVE_W{1'b1}})) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        core_req_d   = core_req_q;
        core_op_d    = core_op_q;
        core_addr_d  = core_addr_q;
        core_wdata_d = core_wdata_q;
        core_bytes_d = core_bytes_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_ack_d     = 1'b0;
        mem_ack_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_fire) begin
                    core_req_d = 1'b1;
                    if (gnt_id == GNT_MEM) begin
                        state_d      = ST_BUSY_MEM;
                        core_op_d    = i_mem_op;
                        core_addr_d  = i_mem_addr;
                        core_wdata_d = i_mem_wdata;
                        core_bytes_d = i_mem_bytes;
                    end else begin
                        // IF is read-only: never let stale write fields reach the core.
                        state_d      = ST_BUSY_IF;
                        core_op_d    = 1'b0;
                        core_addr_d  = i_if_addr;
                        core_wdata_d = '0;
                        core_bytes_d = i_if_bytes;
                    end
                end
            end
            ST_BUSY_IF: begin
                if (i_core_ack) begin
                    core_req_d = 1'b0;
                    if_rdata_d = i_core_rdata;
                    if_ack_d   = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_BUSY_MEM: begin
                if (i_core_ack) begin
                    core_req_d = 1'b0;
                    // Writes return nothing useful; keep the last read data visible.
                    if (!core_op_q) begin
                        mem_rdata_d = i_core_rdata;
                    end
                    mem_ack_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                // Gives the requester the ack cycle to drop or change its request.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            core_req_q   <= 1'b0;
            core_op_q    <= 1'b0;
            core_addr_q  <= '0;
            core_wdata_q <= '0;
            core_bytes_q <= '0;
            if_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            mem_rdata_q  <= '0;
            mem_ack_q    <= 1'b0;
`ifdef CACHE_ARB_RR_EN
            last_gnt_q   <= GNT_IF;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            core_req_q   <= core_req_d;
            core_op_q    <= core_op_d;
            core_addr_q  <= core_addr_d;
            core_wdata_q <= core_wdata_d;
            core_bytes_q <= core_bytes_d;
            if_rdata_q   <= if_rdata_d;
            if_ack_q     <= if_ack_d;
            mem_rdata_q  <= mem_rdata_d;
            mem_ack_q    <= mem_ack_d;
`ifdef CACHE_ARB_RR_EN
            last_gnt_q   <= last_gnt_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    assign o_core_req   = core_req_q;
    assign o_core_op    = core_op_q;
    assign o_core_addr  = core_addr_q;
    assign o_core_wdata = core_wdata_q;
    assign o_core_bytes = core_bytes_q;
    assign o_if_rdata   = if_rdata_q;
    assign o_if_ack     = if_ack_q;
    assign o_mem_rdata  = mem_rdata_q;
    assign o_mem_ack    = mem_ack_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - scoreboard bench for cache_arbiter with a behavioural cache core
module tb_cache_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_if_req;
    logic [63:0] i_if_addr;
    logic [2:0]  i_if_bytes;
    logic [63:0] o_if_rdata;
    logic        o_if_ack;
    logic        i_mem_req;
    logic        i_mem_op;
    logic [63:0] i_mem_addr;
    logic [63:0] i_mem_wdata;
    logic [2:0]  i_mem_bytes;
    logic [63:0] o_mem_rdata;
    logic        o_mem_ack;
    logic        o_core_req;
    logic        o_core_op;
    logic [63:0] o_core_addr;
    logic [63:0] o_core_wdata;
    logic [2:0]  o_core_bytes;
    logic [63:0] i_core_rdata;
    logic        i_core_ack;

    always #5 clk = ~clk;

    cache_arbiter #(.STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_if_req     (i_if_req),
        .i_if_addr    (i_if_addr),
        .i_if_bytes   (i_if_bytes),
        .o_if_rdata   (o_if_rdata),
        .o_if_ack     (o_if_ack),
        .i_mem_req    (i_mem_req),
        .i_mem_op     (i_mem_op),
        .i_mem_addr   (i_mem_addr),
        .i_mem_wdata  (i_mem_wdata),
        .i_mem_bytes  (i_mem_bytes),
        .o_mem_rdata  (o_mem_rdata),
        .o_mem_ack    (o_mem_ack),
        .o_core_req   (o_core_req),
        .o_core_op    (o_core_op),
        .o_core_addr  (o_core_addr),
        .o_core_wdata (o_core_wdata),
        .o_core_bytes (o_core_bytes),
        .i_core_rdata (i_core_rdata),
        .i_core_ack   (i_core_ack)
    );

    typedef struct packed {
        logic        op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  bytes;
        logic [63:0] rdata;
    } core_t;

    core_t       exp_core[$];
    logic [63:0] exp_if[$];
    logic [63:0] exp_mem[$];
    logic [63:0] last_mem_rdata = '0;
    logic [63:0] rsp_rdata = '0;
    int          core_lat = 2;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    function automatic core_t mk(input logic op, input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [2:0] bytes, input logic [63:0] rdata);
        core_t c;
        c.op = op; c.addr = addr; c.wdata = wdata; c.bytes = bytes; c.rdata = rdata;
        return c;
    endfunction

    // Behavioural cache core: acks core_lat cycles after it sees the request.
    initial begin
        int lat_cnt;
        lat_cnt      = 0;
        i_core_ack   = 1'b0;
        i_core_rdata = '0;
        forever begin
            @(negedge clk);
            i_core_ack = 1'b0;
            if (rst && o_core_req) begin
                lat_cnt++;
                if (lat_cnt >= core_lat) begin
                    i_core_ack   = 1'b1;
                    i_core_rdata = rsp_rdata;
                    lat_cnt      = 0;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Monitor: checks every new core transaction and every requester ack.
    initial begin
        logic  core_req_prev, if_ack_prev, mem_ack_prev;
        core_t e;
        core_req_prev = 1'b0; if_ack_prev = 1'b0; mem_ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (o_core_req && !core_req_prev) begin
                    if (exp_core.size() == 0) begin
                        chk("core_unexpected_req", o_core_req, 0);
                    end else begin
                        e = exp_core.pop_front();
                        chk("core_op", o_core_op, e.op);
                        chk("core_addr", o_core_addr, e.addr);
                        chk("core_wdata", o_core_wdata, e.wdata);
                        chk("core_bytes", o_core_bytes, e.bytes);
                        rsp_rdata = e.rdata;
                    end
                end
                if (o_if_ack) begin
                    chk("if_ack_single", if_ack_prev, 0);
                    if (exp_if.size() == 0) chk("if_unexpected_ack", o_if_ack, 0);
                    else chk("if_rdata", o_if_rdata, exp_if.pop_front());
                end
                if (o_mem_ack) begin
                    chk("mem_ack_single", mem_ack_prev, 0);
                    if (exp_mem.size() == 0) chk("mem_unexpected_ack", o_mem_ack, 0);
                    else chk("mem_rdata", o_mem_rdata, exp_mem.pop_front());
                end
            end
            core_req_prev = o_core_req;
            if_ack_prev   = o_if_ack;
            mem_ack_prev  = o_mem_ack;
        end
    end

    task automatic wait_ack(input bit is_mem, input bit drop);
        int   cyc;
        logic ack;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            ack = is_mem ? o_mem_ack : o_if_ack;
        end while (!ack && cyc < 200);
        chk(is_mem ? "mem_ack_timeout" : "if_ack_timeout", ack, 1);
        if (drop) begin
            if (is_mem) begin i_mem_req = 1'b0; i_mem_op = 1'b0; end
            else i_if_req = 1'b0;
        end
    endtask

    task automatic exp_if_txn(input logic [63:0] addr, input logic [2:0] bytes, input logic [63:0] rdata);
        exp_core.push_back(mk(1'b0, addr, 64'h0, bytes, rdata));
        exp_if.push_back(rdata);
    endtask

    task automatic exp_mem_txn(input logic op, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [2:0] bytes, input logic [63:0] rdata);
        exp_core.push_back(mk(op, addr, wdata, bytes, rdata));
        if (!op) last_mem_rdata = rdata;
        exp_mem.push_back(last_mem_rdata);
    endtask

    task automatic req_if(input logic [63:0] addr, input logic [2:0] bytes, input bit drop);
        i_if_req = 1'b1; i_if_addr = addr; i_if_bytes = bytes;
        wait_ack(1'b0, drop);
    endtask

    task automatic req_mem(input logic op, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [2:0] bytes, input bit drop);
        i_mem_req = 1'b1; i_mem_op = op; i_mem_addr = addr; i_mem_wdata = wdata; i_mem_bytes = bytes;
        wait_ack(1'b1, drop);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_core_req"}, o_core_req, 0);
        chk({tag, "_core_op_bytes"}, {o_core_op, o_core_bytes}, 0);
        chk({tag, "_core_addr"}, o_core_addr, 0);
        chk({tag, "_core_wdata"}, o_core_wdata, 0);
        chk({tag, "_acks"}, {o_if_ack, o_mem_ack}, 0);
        chk({tag, "_if_rdata"}, o_if_rdata, 0);
        chk({tag, "_mem_rdata"}, o_mem_rdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b0;
        i_if_req = 1'b0; i_if_addr = '0; i_if_bytes = '0;
        i_mem_req = 1'b0; i_mem_op = 1'b0; i_mem_addr = '0; i_mem_wdata = '0; i_mem_bytes = '0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // IF-only read: core req one cycle after req, requester ack one cycle after core ack.
        exp_if_txn(64'h8000_0000, 3'd3, 64'h1234);
        i_if_req = 1'b1; i_if_addr = 64'h8000_0000; i_if_bytes = 3'd3;
        @(negedge clk);
        chk("core_req_latency", o_core_req, 1);
        cyc = 1;
        while (!o_if_ack && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("if_ack_latency", cyc, 3);
        i_if_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_second_txn", o_core_req, 0);

        // Held IF req with new fields in the DONE cycle: re-arbitrated only from IDLE.
        exp_if_txn(64'h8000_0008, 3'd7, 64'h77);
        req_if(64'h8000_0008, 3'd7, 1'b0);
        exp_if_txn(64'h8000_0040, 3'd1, 64'h88);
        i_if_addr = 64'h8000_0040; i_if_bytes = 3'd1;
        @(negedge clk);
        chk("held_req_idle_gap", o_core_req, 0);
        @(negedge clk);
        chk("held_req_regrant", o_core_req, 1);
        wait_ack(1'b0, 1'b1);
        repeat (2) @(negedge clk);

        // MEM write, read, write: writes leave o_mem_rdata alone.
        exp_mem_txn(1'b1, 64'h8000_0010, 64'hAA, 3'd0, 64'hDEAD);
        req_mem(1'b1, 64'h8000_0010, 64'hAA, 3'd0, 1'b1);
        exp_mem_txn(1'b0, 64'h100, 64'h0, 3'd7, 64'h5555_AAAA);
        req_mem(1'b0, 64'h100, 64'h0, 3'd7, 1'b1);
        exp_mem_txn(1'b1, 64'h108, 64'hFFFF_0000_1111_2222, 3'd7, 64'hBEEF);
        req_mem(1'b1, 64'h108, 64'hFFFF_0000_1111_2222, 3'd7, 1'b1);
        @(negedge clk);
        chk("mem_rdata_hold", o_mem_rdata, 64'h5555_AAAA);
        @(negedge clk);

        // Simultaneous requests; last grant was MEM.
`ifdef CACHE_ARB_RR_EN
        exp_if_txn(64'h200, 3'd7, 64'h2020);
        exp_mem_txn(1'b0, 64'h300, 64'h0, 3'd7, 64'h3030);
`else
        exp_mem_txn(1'b0, 64'h300, 64'h0, 3'd7, 64'h3030);
        exp_if_txn(64'h200, 3'd7, 64'h2020);
`endif
        fork
            req_if(64'h200, 3'd7, 1'b1);
            req_mem(1'b0, 64'h300, 64'h0, 3'd7, 1'b1);
        join
        repeat (2) @(negedge clk);

`ifndef CACHE_ARB_RR_EN
        // MEM held back-to-back with IF waiting: IF wins after exactly four MEM grants.
        for (int k = 0; k < 4; k++) exp_mem_txn(1'b0, 64'hA00 + 64'(k * 8), 64'h0, 3'd7, 64'hB000 + 64'(k));
        exp_if_txn(64'h900, 3'd5, 64'h1F1F);
        for (int k = 4; k < 6; k++) exp_mem_txn(1'b0, 64'hA00 + 64'(k * 8), 64'h0, 3'd7, 64'hB000 + 64'(k));
        fork
            req_if(64'h900, 3'd5, 1'b1);
            begin
                for (int k = 0; k < 6; k++) req_mem(1'b0, 64'hA00 + 64'(k * 8), 64'h0, 3'd7, k == 5);
            end
        join
        repeat (2) @(negedge clk);
`endif

        // Reset while BUSY_MEM, with IF pending; IF is granted normally afterwards.
        core_lat = 50;
        exp_core.push_back(mk(1'b1, 64'h400, 64'hCAFE, 3'd7, 64'h0));
        i_mem_req = 1'b1; i_mem_op = 1'b1; i_mem_addr = 64'h400; i_mem_wdata = 64'hCAFE; i_mem_bytes = 3'd7;
        repeat (3) @(negedge clk);
        chk("busy_mem_core_req", o_core_req, 1);
        i_if_req = 1'b1; i_if_addr = 64'h500; i_if_bytes = 3'd2;
        rst = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midrst");
        i_mem_req = 1'b0; i_mem_op = 1'b0;
        exp_mem.delete();
        core_lat = 2;
        exp_if_txn(64'h500, 3'd2, 64'h5050);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", o_core_req, 1);
        wait_ack(1'b0, 1'b1);
        repeat (3) @(negedge clk);

        chk("exp_core_drained", 64'(exp_core.size()), 0);
        chk("exp_ack_drained", 64'(exp_if.size() + exp_mem.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
